// File: rtl/bcd2binary_if.sv
// Start/busy/done handshake bundle for the iterative BCD-to-binary converter.
interface bcd2binary_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_input;
    logic [BIN_W-1:0]      binary_output;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start, bcd_input,
        input  binary_output, busy, done, err
    );

    modport slave (
        input  start, bcd_input,
        output binary_output, busy, done, err
    );
endinterface

// File: rtl/bcd2binary.sv
// Iterative BCD-to-binary converter (reverse double-dabble), one bit per cycle.
// Optional digit validity check enabled by BCD2BINARY_DIGIT_CHECK_EN.
module bcd2binary #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic        clk,
    input  logic        rst,
    bcd2binary_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BIN_W-1:0]   out_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    // Shift and per-nibble correction fused into one next-state value
    always_comb begin
        {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_d[4*i +: 4] >= 4'd8) begin
                bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD2BINARY_DIGIT_CHECK_EN
    logic err_q;
    logic bad_q;

    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD2BINARY_DIGIT_CHECK_EN
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        bcd_q  <= bus.bcd_input;
                        bin_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
`ifdef BCD2BINARY_DIGIT_CHECK_EN
                        err_q  <= 1'b0;
                        if (has_bad_digit(bus.bcd_input)) begin
                            bad_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            bad_q   <= 1'b0;
                            state_q <= SHIFT;
                        end
`else
                        state_q <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
`ifdef BCD2BINARY_DIGIT_CHECK_EN
                    out_q <= bad_q ? '0 : bin_q;
                    err_q <= bad_q;
`else
                    out_q <= bin_q;
`endif
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.binary_output = out_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
`ifdef BCD2BINARY_DIGIT_CHECK_EN
    assign bus.err           = err_q;
`else
    assign bus.err           = 1'b0;
`endif
endmodule

// File: tb/tb_bcd2binary.sv
// Directed-vector bench for bcd2binary: latency, results, start handling, reset abort.
module tb_bcd2binary;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bcd2binary_if #(.DIGITS(4), .BIN_W(14)) bus ();

    bcd2binary #(.DIGITS(4), .BIN_W(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, obs, obs, exp, exp);
        end
    endtask

    // Pulse start for one edge and follow the conversion to its done pulse
    task automatic convert(input string tag, input logic [15:0] bcd,
                           input int exp_val, input int exp_lat,
                           input bit exp_err);
        int lat;
        int busy_n;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bcd_input = bcd;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.bcd_input = 16'($urandom);
        lat    = 0;
        busy_n = bus.busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_n++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy cycles"}, busy_n, exp_lat);
        chk({tag, " value"}, 32'(bus.binary_output), exp_val);
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, " busy at done"}, 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk({tag, " done falls"}, 32'(bus.done), 0);
    endtask

    initial begin
        int done_n;
        int t1;
        int t2;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.bcd_input = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", 32'(bus.binary_output), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset err", 32'(bus.err), 0);
        @(negedge clk);
        rst = 1'b0;

        convert("zero", 16'h0000, 0, 15, 1'b0);
        convert("9999", 16'h9999, 9999, 15, 1'b0);
        convert("1234", 16'h1234, 1234, 15, 1'b0);
        convert("0001", 16'h0001, 1, 15, 1'b0);

        // Second start mid-conversion must be ignored
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bcd_input = 16'h0042;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_n = 0;
        t1     = 0;
        for (int k = 1; k <= 50; k++) begin
            if (k == 5) begin
                bus.start     = 1'b1;
                bus.bcd_input = 16'h1111;
            end
            @(posedge clk);
            #1;
            if (k == 5) bus.start = 1'b0;
            if (bus.done) begin
                done_n++;
                if (t1 == 0) begin
                    t1 = k;
                    chk("ignore value", 32'(bus.binary_output), 42);
                end
            end
        end
        chk("ignore done time", t1, 15);
        chk("ignore done count", done_n, 1);
        chk("ignore final value", 32'(bus.binary_output), 42);

        // start held high: back-to-back conversions 16 cycles apart
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bcd_input = 16'h0100;
        @(posedge clk);
        #1;
        bus.bcd_input = 16'h0777;
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (t1 == 0) begin
                    t1 = k;
                    chk("held first value", 32'(bus.binary_output), 100);
                end else if (t2 == 0) begin
                    t2 = k;
                    chk("held second value", 32'(bus.binary_output), 777);
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        chk("held first time", t1, 15);
        chk("held spacing", t2 - t1, 16);

        // Reset mid-conversion aborts without done
        @(negedge clk);
        bus.start     = 1'b1;
        bus.bcd_input = 16'h5000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        done_n = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", 32'(bus.busy), 0);
        chk("abort out", 32'(bus.binary_output), 0);
        chk("abort done", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_n++;
        end
        chk("abort no done", done_n, 0);
        convert("after abort", 16'h0010, 10, 15, 1'b0);

`ifdef BCD2BINARY_DIGIT_CHECK_EN
        convert("bad digit", 16'h12A4, 0, 1, 1'b1);
        chk("bad digit err holds", 32'(bus.err), 1);
        convert("after bad", 16'h0099, 99, 15, 1'b0);
`else
        convert("0099", 16'h0099, 99, 15, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd2binary.md
Name: bcd2binary

Overview:
- Iterative 4-digit BCD to binary converter using the reverse double-dabble algorithm: shift right one bit per cycle, then subtract 3 from each BCD nibble that is >= 8.
- The inverse path of the binary-to-BCD display converter. Used where decimal user entry (digit keys, thumbwheels) must be turned back into a binary operand.
- Interface is a start/busy/done handshake; the result is held until the next conversion completes.

Parameters:
- DIGITS, 4, number of BCD input digits.
- BIN_W, 14, result width; must satisfy 10^DIGITS - 1 < 2^BIN_W.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_input  input  4*DIGITS  packed digits; most significant digit in the MSBs, d0 in [3:0].
- binary_output  output  BIN_W  registered result, held between conversions.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when binary_output is updated.
- err  output  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset: rst high at a rising edge forces, on that edge:
  - state = IDLE
  - binary_output = 0, busy = 0, done = 0, err = 0
  - internal shift registers and counter cleared
  - rst overrides every other input, including mid-conversion; the aborted conversion produces no done pulse.
- Internal storage: bcd_reg (4*DIGITS bits), bin_reg (BIN_W bits), cnt (iteration counter, wide enough for BIN_W-1).
- IDLE:
  - done = 0.
  - When start = 1: bcd_reg <= bcd_input, bin_reg <= 0, cnt <= 0, busy <= 1, err <= 0, go to SHIFT.
  - When start = 0: stay in IDLE; outputs hold.
- SHIFT (one iteration per cycle):
  - Shift the concatenation {bcd_reg, bin_reg} right by 1. The bcd_reg LSB enters the bin_reg MSB; 0 enters the bcd_reg MSB.
  - On the shifted value, each nibble >= 8 is reduced by 3 (4-bit arithmetic, no borrow between nibbles).
  - The shift and the correction are combined into a single registered update per cycle.
  - If cnt == BIN_W-1, go to DONE; otherwise cnt <= cnt + 1.
- DONE:
  - binary_output <= bin_reg, done <= 1, busy <= 0, go to IDLE.
  - done falls on the following edge.
- Latency: start sampled at edge E0; SHIFT iterations at E1..E14 (BIN_W = 14); DONE at E15.
  - busy is high after E0 through E15; binary_output and done update at E15.
  - Total 16 cycles from start to done, including the done cycle.
- start while busy or in DONE is ignored; no queuing.
- start may be held high: a new conversion begins on the first IDLE cycle, giving back-to-back results every 16 cycles.
- bcd_input may change freely after the sampling edge.
- After BIN_W iterations, bcd_reg must be all-zero for valid input.

Optional Feature:
- Macro: BCD2BINARY_DIGIT_CHECK_EN.
- Defined:
  - In IDLE with start = 1, any input nibble > 9 sends the FSM directly to DONE instead of SHIFT.
  - DONE then loads binary_output <= 0 and sets err <= 1; done pulses at E1 (2-cycle latency).
  - err holds until the next accepted start or reset.
- Not defined:
  - err is tied to 0 and no check is made.
  - Invalid nibbles are converted anyway; the result is unspecified.

Test Plan:
- Reset, then start with 0x0000 -> done at E15, binary_output = 0, busy high exactly 15 cycles.
- start with 0x9999 -> binary_output = 9999 (14'h270F) with done pulse at E15; 0x1234 -> 14'h04D2; 0x0001 -> 1.
- start asserted again at E5 of a conversion of 0x0042 -> ignored; single done, result 42; no second done.
- start held high, inputs 0x0100 then 0x0777 -> results 100 then 777 on done pulses 16 cycles apart.
- rst asserted at E7 of a conversion of 0x5000 -> busy = 0, binary_output = 0, no done pulse; the next start with 0x0010 gives 10.
- Macro defined, start with 0x12A4 -> done at E1, err = 1, binary_output = 0; next start with 0x0099 -> err = 0, result 99.
